// File: rtl/icon_tx_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : icon_tx_queue_if
// Purpose  : Enqueue / TX-channel bundle between an ALU result port and icon.
// Revision : 1.0 - initial release
// ============================================================================
interface icon_tx_queue_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_EU     = 4,
    parameter int NUM_REG    = 16,
    parameter int DEPTH      = 4
);
    localparam int c_eu_w  = (NUM_EU  > 1) ? $clog2(NUM_EU)  : 1;
    localparam int c_reg_w = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic                  enq_valid;
    logic                  enq_ready;
    logic [DATA_WIDTH-1:0] enq_data;
    logic [c_eu_w-1:0]     enq_eu_idx;
    logic [c_reg_w-1:0]    enq_reg_idx;
    logic                  enq_opx;
    logic                  tx_valid;
    logic [DATA_WIDTH-1:0] tx_data;
    logic [c_eu_w-1:0]     tx_eu_idx;
    logic [c_reg_w-1:0]    tx_reg_idx;
    logic                  tx_opx;
    logic                  rx_success;
    logic [c_cnt_w-1:0]    count;
    logic                  retry_stall;

    // master is the queue itself; slave is the ALU/interconnect side
    modport master (
        input  enq_valid, enq_data, enq_eu_idx, enq_reg_idx, enq_opx, rx_success,
        output enq_ready, tx_valid, tx_data, tx_eu_idx, tx_reg_idx, tx_opx,
               count, retry_stall
    );

    modport slave (
        output enq_valid, enq_data, enq_eu_idx, enq_reg_idx, enq_opx, rx_success,
        input  enq_ready, tx_valid, tx_data, tx_eu_idx, tx_reg_idx, tx_opx,
               count, retry_stall
    );
endinterface
`default_nettype wire

// File: rtl/icon_tx_queue.sv
`default_nettype none
// ============================================================================
// Module   : icon_tx_queue
// Purpose  : Circular TX queue for results bound to foreign execution units,
//            with head retry until success and a saturating retry monitor.
// Revision : 1.0 - initial release
// ============================================================================
module icon_tx_queue #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_EU      = 4,
    parameter int NUM_REG     = 16,
    parameter int DEPTH       = 4,   // >= 2, any value
    parameter int RETRY_LIMIT = 7    // >= 1
) (
    input  wire logic         clk,
    input  wire logic         reset,
    icon_tx_queue_if.master   bus
);
    localparam int c_eu_w  = (NUM_EU  > 1) ? $clog2(NUM_EU)  : 1;
    localparam int c_reg_w = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;
    localparam int c_ent_w = DATA_WIDTH + c_eu_w + c_reg_w + 1;
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam int c_rc_w  = $clog2(RETRY_LIMIT + 1);

    localparam logic [c_ptr_w-1:0] c_last_ptr  = c_ptr_w'(DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_depth_cnt = c_cnt_w'(DEPTH);
    localparam logic [c_rc_w-1:0]  c_retry_max = c_rc_w'(RETRY_LIMIT);

    logic [c_ent_w-1:0] r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [c_rc_w-1:0]  r_retry_cnt;

    logic               w_full;
    logic               w_tx_valid;
    logic               w_enq;
    logic               w_deq;
    logic [c_ent_w-1:0] w_head;

    // enq_ready depends only on registered occupancy, never on rx_success
    assign w_full     = (r_count == c_depth_cnt);
    assign w_tx_valid = (r_count != '0);
    assign w_enq      = bus.enq_valid && !w_full;
    assign w_deq      = w_tx_valid && bus.rx_success;

    always_comb begin
        w_head = '0;
        if (w_tx_valid) begin
            w_head = r_mem[r_rd_ptr];
        end
    end

    assign bus.enq_ready   = !w_full;
    assign bus.tx_valid    = w_tx_valid;
    assign {bus.tx_data, bus.tx_eu_idx, bus.tx_reg_idx, bus.tx_opx} = w_head;
    assign bus.count       = r_count;
    assign bus.retry_stall = (r_retry_cnt == c_retry_max);

    // Storage needs no reset: it is only observed through a valid head.
    always_ff @(posedge clk) begin
        if (!reset && w_enq) begin
            r_mem[r_wr_ptr] <= {bus.enq_data, bus.enq_eu_idx, bus.enq_reg_idx, bus.enq_opx};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_retry_cnt <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
            end

            if (w_enq && !w_deq) begin
                r_count <= r_count + 1'b1;
            end else if (w_deq && !w_enq) begin
                r_count <= r_count - 1'b1;
            end

            if (w_tx_valid && !bus.rx_success) begin
                if (r_retry_cnt != c_retry_max) begin
                    r_retry_cnt <= r_retry_cnt + 1'b1;
                end
            end else begin
                r_retry_cnt <= '0;
            end
        end
    end
endmodule
`default_nettype wire

// File: doc/icon_tx_queue.md
Name: icon_tx_queue

Overview:
- Parametrised transmit queue between an execution unit's ALU result port and the interconnect (icon) TX channel.
- Buffers results destined for foreign execution units, each tagged with eu_idx, reg_idx, opx and data.
- Presents the head entry to the interconnect and retries it every cycle until the interconnect returns success.
- Generalises the single-entry tx/rx channel to configurable depth, data width and address widths, and adds a saturating retry monitor.

Parameters:
- DATA_WIDTH, 16: operand/result word width.
- NUM_EU, 4: number of execution units; eu_idx width EU_W = max(1, clog2(NUM_EU)).
- NUM_REG, 16: registers per execution unit; reg_idx width REG_W = max(1, clog2(NUM_REG)).
- DEPTH, 4: queue entries; must be at least 2; need not be a power of 2.
- RETRY_LIMIT, 7: number of unacknowledged head cycles before retry_stall asserts; must be at least 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- enq_valid  in  1  ALU offers a result.
- enq_ready  out  1  queue can accept; equals !full.
- enq_data  in  DATA_WIDTH  result data.
- enq_eu_idx  in  EU_W  destination execution unit.
- enq_reg_idx  in  REG_W  destination register.
- enq_opx  in  1  destination operand buffer: 0 = op0, 1 = op1.
- tx_valid  out  1  head entry presented to interconnect.
- tx_data  out  DATA_WIDTH  head data.
- tx_eu_idx  out  EU_W  head destination execution unit.
- tx_reg_idx  out  REG_W  head destination register.
- tx_opx  out  1  head opx.
- rx_success  in  1  interconnect accepted the head this cycle.
- count  out  clog2(DEPTH+1)  current occupancy.
- retry_stall  out  1  head has waited RETRY_LIMIT or more cycles without success.

Behaviour:
- Reset (synchronous, active-high):
  - Clears rd_ptr, wr_ptr, count and retry_cnt.
  - tx_valid=0, enq_ready=1, retry_stall=0.
  - tx_data, tx_eu_idx, tx_reg_idx and tx_opx drive 0.
  - Storage contents are don't-care.
  - Reset asserted mid-operation discards all entries; any rx_success in the reset cycle is ignored.
- Enqueue:
  - Occurs when enq_valid && enq_ready at the rising edge: the entry is written at wr_ptr, then wr_ptr advances.
  - enq_ready = !full, with full = (count==DEPTH). There is no combinational path from rx_success to enq_ready.
- Presentation:
  - tx_valid = (count!=0); the tx_* fields are driven combinationally from the storage at rd_ptr.
  - When the queue is empty, tx_* fields read 0.
  - Latency: an entry enqueued into an empty queue is first visible on tx one cycle after the enqueue edge. There is no same-cycle bypass.
- Dequeue:
  - Occurs when tx_valid && rx_success: rd_ptr advances at the edge.
  - rx_success while tx_valid=0 is ignored.
  - The head fields must be held stable while tx_valid=1 and rx_success=0.
- Simultaneous enqueue and dequeue:
  - count is unchanged and both pointers advance.
  - When full, enq_ready=0, so enqueue is blocked even if a dequeue occurs in the same cycle.
- Pointer wrap: a pointer at DEPTH-1 advances to 0.
- count update: +1 on enqueue only, -1 on dequeue only, unchanged otherwise. count never exceeds DEPTH and never goes below 0.
- Retry monitor:
  - retry_cnt has width clog2(RETRY_LIMIT+1).
  - If tx_valid && !rx_success: retry_cnt increments, saturating at RETRY_LIMIT.
  - If a dequeue occurs, or tx_valid=0: retry_cnt becomes 0.
  - retry_stall = (retry_cnt==RETRY_LIMIT). It is advisory only; queue operation continues unchanged.
- Ordering: strict FIFO; entries are never dropped or reordered.

Test Plan:
1. Reset, then enqueue {data=0x1234, eu=2, reg=5, opx=1} with rx_success=0 -> next cycle tx_valid=1, tx_data=0x1234, tx_eu_idx=2, tx_reg_idx=5, tx_opx=1, count=1.
2. DEPTH=4: enqueue 0xA,0xB,0xC,0xD with no success -> count=4, enq_ready=0. Next, a cycle with enq_valid=1 and rx_success=1 -> 0xA popped, new entry not accepted, count=3, tx_data=0xB.
3. Wrap-around: 10 back-to-back enqueues of 1..10 with rx_success held at 1 -> tx_data sequence 1..10 in order, count stays at or below 2, no loss.
4. Simultaneous enqueue and dequeue at count=2 -> count stays 2, FIFO order preserved.
5. RETRY_LIMIT=7: one entry with rx_success=0 for 7 cycles -> retry_stall=1 from the 8th cycle onward. Then rx_success=1 -> entry popped, next cycle retry_stall=0, retry_cnt=0.
6. Reset asserted with count=3 while rx_success=1 -> next cycle count=0, tx_valid=0, enq_ready=1, retry_stall=0.
